// File: rtl/core_regs_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: word/register-number
// types, the R0 constant and the source-index type used for the round-robin pointer.
package core_regs_wb_arbiter_pkg;

  localparam int WORD_W      = 32;
  localparam int REG_NUM_W   = 5;
  localparam int NUM_SRC_MAX = 8;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [REG_NUM_W-1:0] reg_num_t;

  // Wide enough for any legal source count so the pointer type is shared by all builds.
  typedef logic [$clog2(NUM_SRC_MAX)-1:0] src_idx_t;

  localparam reg_num_t R0 = '0;

endpackage

// File: rtl/core_regs_wb_arbiter_if.sv
// Writeback bus between the NUM_SRC requesters and the arbiter, plus the
// registered write-port outputs that feed the register file and forwarding.
interface core_regs_wb_arbiter_if
  import core_regs_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 3
);
  logic     [NUM_SRC-1:0] src_valid;
  reg_num_t [NUM_SRC-1:0] src_r;
  word_t    [NUM_SRC-1:0] src_data;
  logic     [NUM_SRC-1:0] src_ready;

  logic     wr_a_en;
  reg_num_t wr_a_r;
  word_t    wr_a_data;
  logic     wr_b_en;
  reg_num_t wr_b_r;
  word_t    wr_b_data;
  logic     busy;

  modport master (
    output src_valid, src_r, src_data,
    input  src_ready, wr_a_en, wr_a_r, wr_a_data, wr_b_en, wr_b_r, wr_b_data, busy
  );

  modport slave (
    input  src_valid, src_r, src_data,
    output src_ready, wr_a_en, wr_a_r, wr_a_data, wr_b_en, wr_b_r, wr_b_data, busy
  );
endinterface

// File: rtl/core_regs_wb_pick.sv
// Combinational picker: works on masks already rotated so position 0 is the
// round-robin head, and returns the port A / port B positions and R0 acks.
module core_regs_wb_pick
  import core_regs_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 3
) (
  input  logic     [NUM_SRC-1:0] rot_valid,
  input  logic     [NUM_SRC-1:0] rot_r0,
  input  reg_num_t [NUM_SRC-1:0] rot_r,
  output src_idx_t               first_idx,
  output src_idx_t               second_idx,
  output logic                   first_hit,
  output logic                   second_hit,
  output logic     [NUM_SRC-1:0] r0_ack
);

  reg_num_t first_r;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path infers a latch.
    first_idx  = '0;
    second_idx = '0;
    first_hit  = 1'b0;
    second_hit = 1'b0;
    first_r    = '0;
    r0_ack     = rot_valid & rot_r0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (rot_valid[k] && !rot_r0[k]) begin
        if (!first_hit) begin
          first_hit = 1'b1;
          first_idx = src_idx_t'(k);
          first_r   = rot_r[k];
        end else if (!second_hit && rot_r[k] != first_r) begin
          // A same-register candidate is skipped so both ports never hit one register.
          second_hit = 1'b1;
          second_idx = src_idx_t'(k);
        end
      end
    end
  end

endmodule

// File: rtl/core_regs_wb_arbiter.sv
// Round-robin arbiter granting up to two writeback sources per cycle onto the
// register file's write ports A and B; R0 writes are acknowledged without a port.
module core_regs_wb_arbiter
  import core_regs_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 3
) (
  input logic                  clk,
  input logic                  rst,
  core_regs_wb_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  typedef logic [IDX_W-1:0] sel_t;

  src_idx_t rr_ptr_q, rr_ptr_d;

  logic     [NUM_SRC-1:0] rot_valid, rot_r0, rot_r0_ack, r0_ack, ready;
  reg_num_t [NUM_SRC-1:0] rot_r;
  sel_t     [NUM_SRC-1:0] rot_src;
  src_idx_t               first_idx, second_idx;
  logic                   first_hit, second_hit;
  sel_t                   a_sel, b_sel;

  logic     wr_a_en_q, wr_a_en_d, wr_b_en_q, wr_b_en_d;
  reg_num_t wr_a_r_q, wr_a_r_d, wr_b_r_q, wr_b_r_d;
  word_t    wr_a_data_q, wr_a_data_d, wr_b_data_q, wr_b_data_d;

  // Rotated position k corresponds to source (rr_ptr + k) mod NUM_SRC.
  always_comb begin
    rot_src   = '0;
    rot_valid = '0;
    rot_r0    = '0;
    rot_r     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rot_src[k]   = sel_t'((int'(rr_ptr_q) + k) % NUM_SRC);
      rot_valid[k] = bus.src_valid[rot_src[k]];
      rot_r[k]     = bus.src_r[rot_src[k]];
      rot_r0[k]    = (bus.src_r[rot_src[k]] == R0);
    end
  end

  core_regs_wb_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .rot_valid  (rot_valid),
    .rot_r0     (rot_r0),
    .rot_r      (rot_r),
    .first_idx  (first_idx),
    .second_idx (second_idx),
    .first_hit  (first_hit),
    .second_hit (second_hit),
    .r0_ack     (rot_r0_ack)
  );

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    r0_ack = '0;
    ready  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (first_idx == src_idx_t'(k))  a_sel = rot_src[k];
      if (second_idx == src_idx_t'(k)) b_sel = rot_src[k];
      if (rot_r0_ack[k])               r0_ack[rot_src[k]] = 1'b1;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      ready[i] = !rst && (r0_ack[i] ||
                          (first_hit  && a_sel == sel_t'(i)) ||
                          (second_hit && b_sel == sel_t'(i)));
    end
  end

  assign bus.src_ready = ready;
  assign bus.busy      = |(bus.src_valid & ~ready);

  // Idle cycles drop the enables but keep register number and data.
  always_comb begin
    wr_a_en_d   = first_hit;
    wr_a_r_d    = wr_a_r_q;
    wr_a_data_d = wr_a_data_q;
    wr_b_en_d   = second_hit;
    wr_b_r_d    = wr_b_r_q;
    wr_b_data_d = wr_b_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (first_hit) begin
      wr_a_r_d    = bus.src_r[a_sel];
      wr_a_data_d = bus.src_data[a_sel];
      rr_ptr_d    = src_idx_t'((int'(a_sel) + 1) % NUM_SRC);
    end
    if (second_hit) begin
      wr_b_r_d    = bus.src_r[b_sel];
      wr_b_data_d = bus.src_data[b_sel];
      rr_ptr_d    = src_idx_t'((int'(b_sel) + 1) % NUM_SRC);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      rr_ptr_q    <= '0;
      wr_a_en_q   <= 1'b0;
      wr_a_r_q    <= '0;
      wr_a_data_q <= '0;
      wr_b_en_q   <= 1'b0;
      wr_b_r_q    <= '0;
      wr_b_data_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_a_en_q   <= wr_a_en_d;
      wr_a_r_q    <= wr_a_r_d;
      wr_a_data_q <= wr_a_data_d;
      wr_b_en_q   <= wr_b_en_d;
      wr_b_r_q    <= wr_b_r_d;
      wr_b_data_q <= wr_b_data_d;
    end
  end

  assign bus.wr_a_en   = wr_a_en_q;
  assign bus.wr_a_r    = wr_a_r_q;
  assign bus.wr_a_data = wr_a_data_q;
  assign bus.wr_b_en   = wr_b_en_q;
  assign bus.wr_b_r    = wr_b_r_q;
  assign bus.wr_b_data = wr_b_data_q;

endmodule
